// File: rtl/init_done_initiator_pkg.sv
// -----------------------------------------------------------------------------
// init_done_initiator_pkg
// Shared definitions for the INIT/DONE handshake initiator:
//   - state_e     : 3-bit FSM state encoding
//   - DEFAULT_*   : default INIT hold length and DONE timeout
//   - CNT_W/CNT_MAX: width and saturation value of the latency counter
// -----------------------------------------------------------------------------
package init_done_initiator_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ISSUE        = 3'd1,
        WAIT_DONE    = 3'd2,
        WAIT_RELEASE = 3'd3,
        COMPLETE     = 3'd4,
        ERROR        = 3'd5
    } state_e;

    localparam int DEFAULT_INIT_HOLD = 2;
    localparam int DEFAULT_TIMEOUT   = 200;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/init_done_initiator_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// 8-bit up counter that sticks at its maximum value instead of wrapping.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, clears the count
//   clear  in   synchronous clear, takes priority over enable
//   enable in   count up by one this cycle (unless saturated)
//   count  out  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter
    import init_done_initiator_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/init_done_initiator.sv
// -----------------------------------------------------------------------------
// init_done_initiator
// Issues an INIT command to a control unit on a processor start request,
// waits for the DONE level to rise and fall again, measures the INIT-rise to
// DONE-rise latency and flags a sticky timeout if DONE never arrives.
// Parameters:
//   INIT_HOLD  cycles INIT is held high per request (1..15)
//   TIMEOUT    max cycles from INIT rise to DONE rise (2..255)
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   processor request, sampled every cycle
//   DONE     in   completion level from the control unit
//   INIT     out  start command to the control unit
//   busy     out  high from accepted start until back in IDLE
//   ready    out  one-cycle pulse on successful completion
//   timeout  out  sticky error flag, cleared by the next accepted start
//   latency  out  INIT-rise to DONE-rise cycles of the last good transaction
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module init_done_initiator
    import init_done_initiator_pkg::*;
#(
    parameter int INIT_HOLD = DEFAULT_INIT_HOLD,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             DONE,
    output logic             INIT,
    output logic             busy,
    output logic             ready,
    output logic             timeout,
    output logic [CNT_W-1:0] latency
);

    localparam logic [3:0]       HOLD_LAST     = 4'(INIT_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic             timeout_q, timeout_d;
    logic             init_q, busy_q, ready_q;

    logic             cnt_clear;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt_value;

    sat_counter u_sat_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt_value)
    );

    // Next-state logic. The counter runs through ISSUE and WAIT_DONE, so its
    // value while in WAIT_DONE is exactly the distance from the INIT rise.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        latency_d  = latency_q;
        timeout_d  = timeout_q;
        cnt_clear  = 1'b0;
        cnt_enable = (state_q == ISSUE) || (state_q == WAIT_DONE);

        case (state_q)
            IDLE: begin
                // A DONE still high from a previous completion blocks a new request.
                if (start && !DONE) begin
                    state_d   = ISSUE;
                    hold_d    = '0;
                    cnt_clear = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            ISSUE: begin
                // DONE seen while still issuing skips the measurement entirely.
                if (DONE) begin
                    state_d = WAIT_RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = WAIT_DONE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (DONE) begin
                    latency_d = cnt_value;
                    state_d   = WAIT_RELEASE;
                end else if (cnt_value >= TIMEOUT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ERROR;
                end
            end
            WAIT_RELEASE: begin
                if (!DONE) begin
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Outputs are decoded from the next state so
    // they line up with the state they describe without any input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            latency_q <= '0;
            timeout_q <= 1'b0;
            init_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            latency_q <= latency_d;
            timeout_q <= timeout_d;
            init_q    <= (state_d == ISSUE);
            busy_q    <= (state_d != IDLE);
            ready_q   <= (state_d == COMPLETE);
        end
    end

    assign INIT    = init_q;
    assign busy    = busy_q;
    assign ready   = ready_q;
    assign timeout = timeout_q;
    assign latency = latency_q;

endmodule

// File: tb/tb_init_done_initiator.sv
// -----------------------------------------------------------------------------
// tb_init_done_initiator
// Self-checking bench for init_done_initiator. Transactions push their
// expected ready/timeout event (cycle, latency, kind) into a queue; a monitor
// pops and compares when the DUT raises ready or timeout. A second instance
// with INIT_HOLD=4 covers DONE arriving while INIT is still being issued.
// -----------------------------------------------------------------------------
module tb_init_done_initiator;

    typedef struct {
        int         cycle;
        logic [7:0] lat;
        bit         isTimeout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, DONE;
    logic       INIT, busy, ready, timeout;
    logic [7:0] latency;

    logic       start4, DONE4;
    logic       INIT4, busy4, ready4, timeout4;
    logic [7:0] latency4;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   initRises = 0;
    int   initHigh = 0;
    int   readyCount = 0;
    logic initPrev = 1'b0;
    logic timeoutPrev = 1'b0;
    exp_t expQ[$];
    bit   done = 1'b0;

    init_done_initiator dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .DONE    (DONE),
        .INIT    (INIT),
        .busy    (busy),
        .ready   (ready),
        .timeout (timeout),
        .latency (latency)
    );

    init_done_initiator #(.INIT_HOLD(4), .TIMEOUT(200)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .DONE    (DONE4),
        .INIT    (INIT4),
        .busy    (busy4),
        .ready   (ready4),
        .timeout (timeout4),
        .latency (latency4)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval following the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic gotoCycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one well-formed transaction starting in the current cycle:
    // DONE rises d cycles after INIT rises and stays high for w cycles.
    task automatic applyStimulus(input int d, input int w);
        int s, r0, h0;
        s  = cyc;
        r0 = initRises;
        h0 = initHigh;
        expQ.push_back('{s + 2 + d + w, 8'(d), 1'b0});
        start = 1'b1;
        gotoCycle(s + 1);
        start = 1'b0;
        gotoCycle(s + 1 + d);
        DONE = 1'b1;
        gotoCycle(s + 1 + d + w);
        DONE = 1'b0;
        gotoCycle(s + 3 + d + w);
        @(negedge clk);
        checkOutput("txn_busy_low", 32'(busy), 32'd0);
        checkOutput("txn_init_bursts", 32'(initRises - r0), 32'd1);
        checkOutput("txn_init_cycles", 32'(initHigh - h0), 32'd2);
    endtask

    // Scoreboard monitor for the default-parameter instance.
    always @(negedge clk) begin
        exp_t e;
        if (INIT === 1'b1 && initPrev !== 1'b1) initRises++;
        if (INIT === 1'b1) initHigh++;
        initPrev = INIT;
        if (ready === 1'b1) begin
            readyCount++;
            if (expQ.size() == 0) begin
                checkOutput("ready_unexpected", 32'(ready), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("ready_kind", 32'(e.isTimeout), 32'd0);
                checkOutput("ready_cycle", 32'(cyc), 32'(e.cycle));
                checkOutput("ready_latency", 32'(latency), 32'(e.lat));
            end
        end
        if (timeout === 1'b1 && timeoutPrev !== 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("timeout_unexpected", 32'(timeout), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("timeout_kind", 32'(e.isTimeout), 32'd1);
                checkOutput("timeout_cycle", 32'(cyc), 32'(e.cycle));
                checkOutput("timeout_latency", 32'(latency), 32'(e.lat));
            end
        end
        timeoutPrev = timeout;
    end

    initial begin
        int b;
        rst    = 1'b1;
        start  = 1'b0;
        DONE   = 1'b0;
        start4 = 1'b0;
        DONE4  = 1'b0;

        // Reset state, with start asserted to confirm reset wins.
        gotoCycle(2);
        start = 1'b1;
        gotoCycle(3);
        @(negedge clk);
        checkOutput("rst_init", 32'(INIT), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_latency", 32'(latency), 32'd0);
        start = 1'b0;
        gotoCycle(4);
        rst = 1'b0;

        // Nominal: start at 10, DONE high 20..50, plus a rejected start at 30.
        gotoCycle(10);
        start = 1'b1;
        expQ.push_back('{52, 8'd9, 1'b0});
        gotoCycle(11);
        start = 1'b0;
        @(negedge clk);
        checkOutput("nom_init_c11", 32'(INIT), 32'd1);
        checkOutput("nom_busy_c11", 32'(busy), 32'd1);
        gotoCycle(12);
        @(negedge clk);
        checkOutput("nom_init_c12", 32'(INIT), 32'd1);
        gotoCycle(13);
        @(negedge clk);
        checkOutput("nom_init_c13", 32'(INIT), 32'd0);
        checkOutput("nom_busy_c13", 32'(busy), 32'd1);
        gotoCycle(20);
        DONE = 1'b1;
        gotoCycle(30);
        start = 1'b1;
        gotoCycle(31);
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy_reject_init", 32'(INIT), 32'd0);
        gotoCycle(51);
        DONE = 1'b0;
        gotoCycle(53);
        @(negedge clk);
        checkOutput("nom_busy_c53", 32'(busy), 32'd0);
        checkOutput("nom_latency", 32'(latency), 32'd9);
        checkOutput("nom_init_bursts", 32'(initRises), 32'd1);
        checkOutput("nom_ready_count", 32'(readyCount), 32'd1);

        // Start while DONE still high is ignored until both DONE drops and start returns.
        gotoCycle(60);
        DONE  = 1'b1;
        start = 1'b1;
        gotoCycle(61);
        @(negedge clk);
        checkOutput("done_high_init", 32'(INIT), 32'd0);
        checkOutput("done_high_busy", 32'(busy), 32'd0);
        gotoCycle(64);
        DONE  = 1'b0;
        start = 1'b0;
        gotoCycle(66);
        @(negedge clk);
        checkOutput("done_high_no_init", 32'(INIT), 32'd0);
        start = 1'b1;
        expQ.push_back('{77, 8'd3, 1'b0});
        gotoCycle(67);
        start = 1'b0;
        @(negedge clk);
        checkOutput("restart_init", 32'(INIT), 32'd1);
        gotoCycle(70);
        DONE = 1'b1;
        gotoCycle(76);
        DONE = 1'b0;
        gotoCycle(78);
        @(negedge clk);
        checkOutput("restart_latency", 32'(latency), 32'd3);

        // Timeout: DONE never rises; latency keeps its previous value.
        gotoCycle(90);
        start = 1'b1;
        expQ.push_back('{292, 8'd3, 1'b1});
        gotoCycle(91);
        start = 1'b0;
        gotoCycle(291);
        @(negedge clk);
        checkOutput("to_not_yet", 32'(timeout), 32'd0);
        checkOutput("to_busy_wait", 32'(busy), 32'd1);
        gotoCycle(293);
        @(negedge clk);
        checkOutput("to_busy_low", 32'(busy), 32'd0);
        checkOutput("to_flag", 32'(timeout), 32'd1);
        checkOutput("to_no_ready", 32'(readyCount), 32'd2);
        gotoCycle(300);
        @(negedge clk);
        checkOutput("to_sticky", 32'(timeout), 32'd1);

        // New start clears timeout; reset during WAIT_DONE aborts with no ready.
        gotoCycle(310);
        start = 1'b1;
        gotoCycle(311);
        start = 1'b0;
        @(negedge clk);
        checkOutput("to_cleared", 32'(timeout), 32'd0);
        checkOutput("abort_init", 32'(INIT), 32'd1);
        gotoCycle(320);
        rst = 1'b1;
        gotoCycle(321);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_init_low", 32'(INIT), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(ready), 32'd0);
        checkOutput("abort_timeout", 32'(timeout), 32'd0);
        checkOutput("abort_latency", 32'(latency), 32'd0);
        gotoCycle(325);
        DONE = 1'b1;
        gotoCycle(331);
        DONE = 1'b0;
        gotoCycle(340);
        @(negedge clk);
        checkOutput("abort_busy_after", 32'(busy), 32'd0);
        checkOutput("abort_ready_count", 32'(readyCount), 32'd2);
        checkOutput("abort_queue_empty", 32'(expQ.size()), 32'd0);

        // A handful of randomised transactions through the scoreboard.
        for (int i = 0; i < 5; i++) begin
            int d, w;
            d = int'($urandom_range(20, 2));
            w = int'($urandom_range(31, 1));
            gotoCycle(cyc + 2);
            applyStimulus(d, w);
        end
        checkOutput("rand_queue_empty", 32'(expQ.size()), 32'd0);

        // INIT_HOLD=4 instance: a measured transaction, then DONE during ISSUE.
        b = cyc + 2;
        gotoCycle(b);
        start4 = 1'b1;
        gotoCycle(b + 1);
        start4 = 1'b0;
        gotoCycle(b + 8);
        DONE4 = 1'b1;
        gotoCycle(b + 11);
        DONE4 = 1'b0;
        gotoCycle(b + 12);
        @(negedge clk);
        checkOutput("h4_ready", 32'(ready4), 32'd1);
        gotoCycle(b + 13);
        @(negedge clk);
        checkOutput("h4_latency", 32'(latency4), 32'd7);
        checkOutput("h4_busy_low", 32'(busy4), 32'd0);

        b = cyc + 2;
        gotoCycle(b);
        start4 = 1'b1;
        gotoCycle(b + 1);
        start4 = 1'b0;
        @(negedge clk);
        checkOutput("early_init_1", 32'(INIT4), 32'd1);
        gotoCycle(b + 2);
        DONE4 = 1'b1;
        @(negedge clk);
        checkOutput("early_init_2", 32'(INIT4), 32'd1);
        gotoCycle(b + 3);
        @(negedge clk);
        checkOutput("early_init_drop", 32'(INIT4), 32'd0);
        checkOutput("early_busy", 32'(busy4), 32'd1);
        gotoCycle(b + 7);
        DONE4 = 1'b0;
        @(negedge clk);
        checkOutput("early_no_ready_yet", 32'(ready4), 32'd0);
        gotoCycle(b + 8);
        @(negedge clk);
        checkOutput("early_ready", 32'(ready4), 32'd1);
        gotoCycle(b + 9);
        @(negedge clk);
        checkOutput("early_ready_once", 32'(ready4), 32'd0);
        checkOutput("early_busy_low", 32'(busy4), 32'd0);
        checkOutput("early_latency_kept", 32'(latency4), 32'd7);
        checkOutput("early_timeout", 32'(timeout4), 32'd0);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("[TB] FAIL watchdog: got timeout expected completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "[TB] watchdog expired");
        end
    end

endmodule

// File: doc/init_done_initiator.md
INIT_DONE_INITIATOR -- requirements
Module: init_done_initiator

Interface
REQ-001 Parameter INIT_HOLD, default 2: cycles INIT is held high per request, legal range 1..15.
REQ-002 Parameter TIMEOUT, default 200: max cycles from INIT rise to DONE rise, legal range 2..255.
REQ-003 clk  input  1  processor clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  processor request; sampled every cycle.
REQ-006 DONE  input  1  from the control unit; level, held high about 31 cycles per completion.
REQ-007 INIT  output  1  start command to the control unit.
REQ-008 busy  output  1  high from accepted start until return to IDLE.
REQ-009 ready  output  1  one-cycle pulse on successful completion.
REQ-010 timeout  output  1  sticky error flag.
REQ-011 latency  output  8  cycles from INIT rise to DONE rise of the last transaction.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from input to output.
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE, WAIT_RELEASE, COMPLETE and ERROR.
REQ-014 IDLE: INIT=0 and busy=0; start=1 with DONE=0 SHALL go to ISSUE; start=1 with DONE=1 SHALL be ignored.
REQ-015 The transition into ISSUE SHALL clear timeout and clear the latency counter.
REQ-016 ISSUE: INIT=1 and busy=1 for exactly INIT_HOLD cycles; INIT SHALL rise the cycle after start is sampled.
REQ-017 ISSUE exit: go to WAIT_DONE after INIT_HOLD cycles; if DONE=1 is sampled earlier, go directly to WAIT_RELEASE.
REQ-018 The latency counter SHALL increment every cycle in ISSUE and WAIT_DONE, saturating at 255.
REQ-019 WAIT_DONE: INIT=0; DONE=1 SHALL capture the counter into latency and go to WAIT_RELEASE.
REQ-020 WAIT_DONE: counter reaching TIMEOUT with DONE=0 SHALL go to ERROR; latency is left unchanged.
REQ-021 WAIT_RELEASE: SHALL hold until DONE=0, then go to COMPLETE; a new start is ignored here.
REQ-022 COMPLETE: ready=1 for exactly one cycle, busy=1, then go to IDLE.
REQ-023 ERROR: timeout=1 for one cycle, then go to IDLE; timeout SHALL stay high until the next accepted start or reset.
REQ-024 start asserted while busy=1 SHALL be ignored and not queued.
REQ-025 A DONE pulse arriving in IDLE with no request outstanding SHALL be ignored.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-027 rst=1 SHALL force IDLE and drive INIT=0, busy=0, ready=0, timeout=0, latency=0, counter=0 on the next edge.
REQ-028 rst SHALL take priority over start, and reset in mid-transaction SHALL abort it with no ready pulse.

Structure
REQ-029 State encodings (3 bits) and the default INIT_HOLD and TIMEOUT values SHALL live in a shared package.
REQ-030 The saturating cycle counter SHALL be one sub-module, sat_counter, with clear, enable and 8-bit count ports.
REQ-031 Target size is 120-250 RTL lines.

Verification
REQ-032 Nominal: start at cycle 10, DONE high cycles 20..50 -> INIT high cycles 11-12, latency=9, ready pulse cycle 52, busy low cycle 53.
REQ-033 Timeout: start, DONE never rises -> timeout=1 about 200 cycles after INIT rise, no ready, busy low one cycle later.
REQ-034 Early DONE: INIT_HOLD=4, DONE rises in the 2nd ISSUE cycle -> INIT drops, FSM enters WAIT_RELEASE, ready follows DONE fall, latency unchanged from the prior transaction.
REQ-035 Busy rejection: second start during WAIT_RELEASE -> ignored; exactly one INIT burst and one ready pulse.
REQ-036 Reset mid-WAIT_DONE -> next cycle all outputs zero, state IDLE; a later DONE produces no ready.
REQ-037 Start while DONE still high -> no INIT until DONE=0 and start is reasserted.
